obj_spawn_ctrl: RTL

//  Sequences spawning of falling objects into the 10-slot x-coordinate register bank.

---
 rtl/spawn_pkg.sv | 26 ++
 rtl/lowest_free_slot.sv | 22 ++
 rtl/obj_spawn_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/spawn_pkg.sv
// Shared spawn-controller encodings and column geometry.
// Defaults are shared with the x register bank and the renderer.
package spawn_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAW,
    S_LOAD
  } state_e;

  localparam int X_STEP_DEF   = 10;
  localparam int X_OFFSET_DEF = 2;
  localparam int MAX_COL_DEF  = 14;

  function automatic logic [7:0] col_to_x(
    input logic [3:0] col,
    input int         step,
    input int         off
  );
    logic [15:0] t;
    t = 16'(col) * 16'(step) + 16'(off);
    return t[7:0];
  endfunction

endpackage

// File: rtl/lowest_free_slot.sv
// Priority encoder: index of the lowest clear bit in the occupancy vector.
module lowest_free_slot #(
  parameter int N  = 10,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  active_i,
  output logic [IW-1:0] idx_o,
  output logic          any_free_o
);

  always_comb begin
    idx_o      = '0;
    any_free_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!active_i[i]) begin
        idx_o      = IW'(i);
        any_free_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/obj_spawn_ctrl.sv
// Spawn sequencer for falling objects: interval timer, column draw, slot load.
// NO_REPEAT_COL_EN rejects a draw equal to the previous column.
module obj_spawn_ctrl
  import spawn_pkg::*;
#(
  parameter int NUM_OBJ        = 10,
  parameter int SPAWN_INTERVAL = 30,
  parameter int X_STEP         = X_STEP_DEF,
  parameter int X_OFFSET       = X_OFFSET_DEF,
  parameter int MAX_COL        = MAX_COL_DEF,
  parameter int RETRY_MAX      = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable,
  input  logic               tick,
  input  logic [3:0]         rand_int,
  input  logic [NUM_OBJ-1:0] obj_done,
  output logic [NUM_OBJ-1:0] load_x,
  output logic [7:0]         x_val,
  output logic [NUM_OBJ-1:0] active,
  output logic               full
);

  localparam int CW = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
  localparam int RW = $clog2(RETRY_MAX + 1);
  localparam int SW = $clog2(NUM_OBJ);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic [NUM_OBJ-1:0] active_q, active_d;
  logic [3:0]         last_col_q, last_col_d;
  logic               last_vld_q, last_vld_d;
  logic [NUM_OBJ-1:0] load_x_q, load_x_d;
  logic [7:0]         x_val_q, x_val_d;

  logic [SW-1:0] free_slot;
  logic          any_free;
  logic          draw_ok;
  logic          do_load;
  logic [3:0]    col;
  logic [3:0]    fb_col;

  lowest_free_slot #(
    .N  (NUM_OBJ),
    .IW (SW)
  ) u_free (
    .active_i   (active_q),
    .idx_o      (free_slot),
    .any_free_o (any_free)
  );

`ifdef NO_REPEAT_COL_EN
  assign draw_ok = (rand_int <= 4'(MAX_COL)) &&
                   !(last_vld_q && rand_int == last_col_q);
`else
  assign draw_ok = rand_int <= 4'(MAX_COL);
`endif

  // Fallback steps past the previous column so it never repeats.
  assign fb_col = !last_vld_q ? 4'd0 :
                  (last_col_q == 4'(MAX_COL)) ? 4'd0 :
                  last_col_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    active_d   = active_q & ~obj_done;
    last_col_d = last_col_q;
    last_vld_d = last_vld_q;
    load_x_d   = '0;
    x_val_d    = x_val_q;
    do_load    = 1'b0;
    col        = rand_int;
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_WAIT;
        S_WAIT: begin
          if (tick) begin
            if (cnt_q == CW'(SPAWN_INTERVAL - 1)) begin
              if (any_free) begin
                state_d = S_DRAW;
                cnt_d   = '0;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_DRAW: begin
          if (draw_ok) begin
            do_load = 1'b1;
          end else if (retry_q == RW'(RETRY_MAX - 1)) begin
            do_load = 1'b1;
            col     = fb_col;
          end else begin
            retry_d = retry_q + 1'b1;
          end
        end
        S_LOAD: begin
          state_d = S_WAIT;
          retry_d = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (do_load) begin
      state_d             = S_LOAD;
      retry_d             = '0;
      load_x_d            = NUM_OBJ'(1) << free_slot;
      x_val_d             = col_to_x(col, X_STEP, X_OFFSET);
      active_d[free_slot] = 1'b1;
      last_col_d          = col;
      last_vld_d          = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      retry_q    <= '0;
      active_q   <= '0;
      last_col_q <= '0;
      last_vld_q <= 1'b0;
      load_x_q   <= '0;
      x_val_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      active_q   <= active_d;
      last_col_q <= last_col_d;
      last_vld_q <= last_vld_d;
      load_x_q   <= load_x_d;
      x_val_q    <= x_val_d;
    end
  end

  assign load_x = load_x_q;
  assign x_val  = x_val_q;
  assign active = active_q;
  assign full   = &active_q;

endmodule
